// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, fetch states, word type.
package y86_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned LEN_W  = 4;

  typedef logic [WORD_W-1:0] word_t;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  typedef enum logic [2:0] {
    FETCH0,
    FETCH_REG,
    FETCH_C,
    DONE,
    WAIT,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/instr_len.sv
// Instruction length decoder: icode -> byte length and validity.
module instr_len
  import y86_pkg::*;
(
  input  logic [3:0]       icode,
  output logic [LEN_W-1:0] len,
  output logic             valid
);

  // Invalid codes report length 1 so the fetch consumes only the opcode byte.
  always_comb begin
    len   = LEN_W'(1);
    valid = 1'b1;
    case (icode)
      HALT, NOP, RET:               len = LEN_W'(1);
      RRMOVQ, OPQ, PUSHQ, POPQ:     len = LEN_W'(2);
      JXX, CALL:                    len = LEN_W'(9);
      IRMOVQ, RMMOVQ, MRMOVQ:       len = LEN_W'(10);
      default: begin
        len   = LEN_W'(1);
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_seq.sv
// Byte-serial Y86-64 instruction fetch sequencer with registered decode outputs.
module fetch_seq
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_load,
  input  word_t       next_pc,
  output logic        imem_req,
  output word_t       imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_data,
  input  logic        imem_err,
  output logic        f_valid,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output word_t       valC,
  output word_t       valP,
  output word_t       pc,
  output logic        halted,
  output logic        instr_err,
  output logic        mem_err
);

  fetch_state_t     state;
  logic [LEN_W-1:0] len_q;
  logic [2:0]       cbyte;
  logic [LEN_W-1:0] dec_len;
  logic             dec_valid;
  logic             take_c;
  logic             finish_c;
  logic [LEN_W-1:0] cur_len_c;
  logic             is_jump_c;

  instr_len u_len (
    .icode (imem_data[7:4]),
    .len   (dec_len),
    .valid (dec_valid)
  );

  // Accepted byte this cycle and whether it is the last one of the instruction.
  always_comb begin
    take_c    = imem_req & imem_ack;
    is_jump_c = (imem_data[7:4] == JXX) || (imem_data[7:4] == CALL);
    cur_len_c = (state == FETCH0) ? dec_len : len_q;
    finish_c  = 1'b0;
    if (take_c) begin
      case (state)
        FETCH0:    finish_c = imem_err || !dec_valid || (dec_len == LEN_W'(1));
        FETCH_REG: finish_c = imem_err || (len_q != LEN_W'(10));
        FETCH_C:   finish_c = imem_err || (cbyte == 3'd7);
        default:   finish_c = 1'b0;
      endcase
    end
  end

  // Fetch state machine; the finish block overrides the per-state next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH0;
      pc        <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      f_valid   <= 1'b0;
      icode     <= '0;
      ifun      <= '0;
      rA        <= '0;
      rB        <= '0;
      valC      <= '0;
      valP      <= '0;
      halted    <= 1'b0;
      instr_err <= 1'b0;
      mem_err   <= 1'b0;
      len_q     <= '0;
      cbyte     <= '0;
    end else begin
      f_valid <= 1'b0;
      case (state)
        FETCH0: begin
          if (!imem_req) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
            icode     <= '0;
            ifun      <= '0;
            rA        <= 4'hF;
            rB        <= 4'hF;
            valC      <= '0;
          end else if (take_c && !imem_err) begin
            icode <= imem_data[7:4];
            ifun  <= imem_data[3:0];
            len_q <= dec_len;
            cbyte <= '0;
            if (!dec_valid) begin
              instr_err <= 1'b1;
            end else if (is_jump_c) begin
              state <= FETCH_C;
            end else if (dec_len >= LEN_W'(2)) begin
              state <= FETCH_REG;
            end
          end
        end
        FETCH_REG: begin
          if (take_c && !imem_err) begin
            rA    <= imem_data[7:4];
            rB    <= imem_data[3:0];
            state <= FETCH_C;
          end
        end
        FETCH_C: begin
          if (take_c && !imem_err) begin
            valC[{cbyte, 3'b000} +: 8] <= imem_data;
            cbyte <= cbyte + 3'd1;
          end
        end
        DONE: begin
          if (icode == HALT || instr_err || mem_err) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (pc_load) begin
            pc    <= next_pc;
            state <= FETCH0;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= FETCH0;
      endcase

      if (take_c) begin
        imem_addr <= imem_addr + WORD_W'(1);
        if (imem_err) mem_err <= 1'b1;
      end

      if (finish_c) begin
        state    <= DONE;
        imem_req <= 1'b0;
        f_valid  <= 1'b1;
        valP     <= pc + WORD_W'(cur_len_c);
      end
    end
  end

endmodule
